// File: rtl/digit_split_scheduler.sv
// Round-robin scheduler sharing one 6-bit-to-BCD splitter among the seconds,
// minutes and hours fields; captures tens/units per field and acks each conversion.
module digit_split_scheduler (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  req,
  input  logic [5:0]  sec_val,
  input  logic [5:0]  min_val,
  input  logic [5:0]  hr_val,
  output logic [5:0]  split_total,
  input  logic [3:0]  split_left,
  input  logic [3:0]  split_right,
  output logic [23:0] digits,
  output logic [2:0]  ack,
  output logic        busy,
  output logic [2:0]  ovf
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [2:0]  pending_r;
  logic [1:0]  last_g_r, cur_r;
  logic [5:0]  split_total_r;
  logic [23:0] digits_r;
  logic [2:0]  ack_r, ovf_r;
  logic        busy_r;
  logic [1:0]  grant_s;
  logic        grant_v_s;
  logic [2:0]  clear_s;
  logic [5:0]  field_val_s;

  // First pending field at or after the slot following the last grant.
  function automatic logic [1:0] rr_pick(input logic [2:0] pend, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = 2'd0;
    found = 1'b0;
    idx   = (last >= 2'd2) ? 2'd0 : last + 2'd1;
    for (int k = 0; k < 3; k++) begin
      if (!found && pend[idx]) begin
        pick  = idx;
        found = 1'b1;
      end else begin
        pick  = pick;
      end
      idx = (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
    end
    return pick;
  endfunction

  function automatic logic [5:0] field_max(input logic [1:0] f);
    logic [5:0] m;
    case (f)
      2'd2:    m = 6'd23;
      default: m = 6'd59;
    endcase
    return m;
  endfunction

  function automatic logic [2:0] onehot3(input logic [1:0] f);
    return 3'b001 << f;
  endfunction

  // Next-state, grant selection and pending clear.
  always_comb begin
    state_nxt_s = state_r;
    grant_s     = rr_pick(pending_r, last_g_r);
    grant_v_s   = 1'b0;
    clear_s     = 3'b000;
    case (state_r)
      IDLE: begin
        if (pending_r != 3'b000) begin
          grant_v_s   = 1'b1;
          clear_s     = onehot3(grant_s);
          state_nxt_s = CONV;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CONV:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Operand mux for the granted field.
  always_comb begin
    field_val_s = 6'd0;
    case (grant_s)
      2'd0:    field_val_s = sec_val;
      2'd1:    field_val_s = min_val;
      2'd2:    field_val_s = hr_val;
      default: field_val_s = 6'd0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Request queue, operand capture and result write-back.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_r     <= 3'b000;
      last_g_r      <= 2'd2;
      cur_r         <= 2'd0;
      split_total_r <= 6'd0;
      digits_r      <= 24'd0;
      ack_r         <= 3'b000;
      ovf_r         <= 3'b000;
      busy_r        <= 1'b0;
    end else begin
      // A request landing on the clear edge re-queues the field.
      pending_r <= (pending_r & ~clear_s) | req;
      busy_r    <= (state_nxt_s == CONV);
      ack_r     <= 3'b000;
      if (grant_v_s) begin
        split_total_r <= field_val_s;
        cur_r         <= grant_s;
        last_g_r      <= grant_s;
      end
      if (state_r == CONV) begin
        digits_r[{cur_r, 3'b000} +: 8] <= {split_left, split_right};
        ack_r                          <= onehot3(cur_r);
        ovf_r[cur_r]                   <= (split_total_r > field_max(cur_r));
      end
    end
  end

  assign split_total = split_total_r;
  assign digits      = digits_r;
  assign ack         = ack_r;
  assign busy        = busy_r;
  assign ovf         = ovf_r;

endmodule

// File: tb/tb_digit_split_scheduler.sv
// Bench for digit_split_scheduler: directed scenarios plus random traffic, each
// cycle compared against a transaction-level model of the round-robin schedule.
module tb_digit_split_scheduler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  req = 3'b000;
  logic [5:0]  sec_val = 6'd0, min_val = 6'd0, hr_val = 6'd0;
  logic [5:0]  split_total;
  logic [3:0]  split_left, split_right;
  logic [23:0] digits;
  logic [2:0]  ack, ovf;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  logic [2:0]  m_pend;
  int          m_last, m_cur, m_op;
  bit          m_inflight;
  logic [23:0] m_dig;
  logic [2:0]  m_ovf, m_ack;

  always #5 clk = ~clk;

  // Shared splitter, behavioural
  always_comb begin
    if (split_total < 6'd60) begin
      split_left  = 4'(split_total / 6'd10);
      split_right = 4'(split_total % 6'd10);
    end else begin
      split_left  = 4'd6;
      split_right = 4'd0;
    end
  end

  digit_split_scheduler dut (
    .clk(clk), .reset_n(reset_n), .req(req),
    .sec_val(sec_val), .min_val(min_val), .hr_val(hr_val),
    .split_total(split_total), .split_left(split_left), .split_right(split_right),
    .digits(digits), .ack(ack), .busy(busy), .ovf(ovf)
  );

  task automatic model_reset();
    m_pend = 3'b000; m_last = 2; m_cur = 0; m_op = 0; m_inflight = 1'b0;
    m_dig = 24'd0; m_ovf = 3'b000; m_ack = 3'b000;
  endtask

  // One rising edge of the schedule, from the rules: serve the in-flight field,
  // else grant the next pending field after the last one served.
  task automatic model_edge();
    int vals[3];
    int tens, units, g;
    logic [2:0] newp;
    vals[0] = int'(sec_val); vals[1] = int'(min_val); vals[2] = int'(hr_val);
    newp  = m_pend;
    m_ack = 3'b000;
    if (m_inflight) begin
      tens  = (m_op < 60) ? m_op / 10 : 6;
      units = (m_op < 60) ? m_op % 10 : 0;
      m_dig[m_cur*8 +: 8] = 8'(tens * 16 + units);
      m_ovf[m_cur] = (m_op > ((m_cur == 2) ? 23 : 59));
      m_ack[m_cur] = 1'b1;
      m_inflight = 1'b0;
    end else if (m_pend != 3'b000) begin
      g = -1;
      for (int k = 1; k <= 3; k++) begin
        if (g < 0 && m_pend[(m_last + k) % 3]) g = (m_last + k) % 3;
      end
      m_op = vals[g]; m_cur = g; m_last = g; newp[g] = 1'b0; m_inflight = 1'b1;
    end
    m_pend = newp | req;
  endtask

  task automatic check_all(input string tag);
    n_assert++;
    assert (split_total === 6'(m_op)) else begin
      n_fail++; $error("FAIL %s split_total observed=%0d expected=%0d", tag, split_total, m_op);
    end
    n_assert++;
    assert (digits === m_dig) else begin
      n_fail++; $error("FAIL %s digits observed=%h expected=%h", tag, digits, m_dig);
    end
    n_assert++;
    assert (ack === m_ack) else begin
      n_fail++; $error("FAIL %s ack observed=%b expected=%b", tag, ack, m_ack);
    end
    n_assert++;
    assert (busy === m_inflight) else begin
      n_fail++; $error("FAIL %s busy observed=%b expected=%b", tag, busy, m_inflight);
    end
    n_assert++;
    assert (ovf === m_ovf) else begin
      n_fail++; $error("FAIL %s ovf observed=%b expected=%b", tag, ovf, m_ovf);
    end
    n_assert++;
    assert ($countones(ack) <= 1) else begin
      n_fail++; $error("FAIL %s ack_onehot observed=%b expected=at most one bit", tag, ack);
    end
  endtask

  task automatic step(input logic [2:0] r, input string tag);
    req = r;
    @(posedge clk);
    model_edge();
    #1 check_all(tag);
  endtask

  // Asynchronous reset applied between edges with random inputs toggling.
  task automatic do_reset(input string tag);
    #2 reset_n = 1'b0;
    model_reset();
    #1 check_all({tag, "_async"});
    req = 3'($urandom); sec_val = 6'($urandom); min_val = 6'($urandom); hr_val = 6'($urandom);
    @(posedge clk);
    @(posedge clk);
    #1 check_all({tag, "_held"});
    req = 3'b000;
    #4 reset_n = 1'b1;
  endtask

  initial begin
    model_reset();
    req = 3'b111; sec_val = 6'd11;
    #3 check_all("por");
    @(posedge clk);
    #1 check_all("por_held");
    req = 3'b000;
    #4 reset_n = 1'b1;
    step(3'b000, "idle0");
    step(3'b000, "idle1");

    // Single seconds request
    sec_val = 6'd37;
    step(3'b001, "single_e0");
    step(3'b000, "single_e1");
    step(3'b000, "single_e2");
    n_assert++;
    assert (digits[7:0] === 8'h37) else begin
      n_fail++; $error("FAIL single_sec_digits observed=%h expected=37", digits[7:0]);
    end
    step(3'b000, "single_e3");

    // Simultaneous requests from a fresh reset
    do_reset("rst_a");
    sec_val = 6'd5; min_val = 6'd42; hr_val = 6'd19;
    step(3'b111, "all_e0");
    for (int i = 1; i <= 7; i++) step(3'b000, "all_run");
    n_assert++;
    assert (digits === 24'h194205) else begin
      n_fail++; $error("FAIL all_digits observed=%h expected=194205", digits);
    end

    // Fairness: seconds and hours held continuously
    for (int i = 0; i < 16; i++) begin
      sec_val = 6'($urandom_range(0, 59)); hr_val = 6'($urandom_range(0, 23));
      step(3'b101, "fair");
    end
    step(3'b000, "fair_tail0");
    step(3'b000, "fair_tail1");
    n_assert++;
    assert (digits[15:8] === 8'h42) else begin
      n_fail++; $error("FAIL fair_min_untouched observed=%h expected=42", digits[15:8]);
    end

    // Overflow flags
    min_val = 6'd60;
    step(3'b010, "ovf_min60");
    step(3'b000, "ovf_min60_g");
    step(3'b000, "ovf_min60_c");
    n_assert++;
    assert (ovf[1] === 1'b1 && digits[15:8] === 8'h60) else begin
      n_fail++; $error("FAIL ovf_min60 observed=%b/%h expected=1/60", ovf[1], digits[15:8]);
    end
    min_val = 6'd59;
    step(3'b010, "ovf_min59");
    step(3'b000, "ovf_min59_g");
    step(3'b000, "ovf_min59_c");
    hr_val = 6'd24;
    step(3'b100, "ovf_hr24");
    step(3'b000, "ovf_hr24_g");
    step(3'b000, "ovf_hr24_c");
    n_assert++;
    assert (ovf === 3'b100 && digits[23:16] === 8'h24) else begin
      n_fail++; $error("FAIL ovf_hr24 observed=%b/%h expected=100/24", ovf, digits[23:16]);
    end

    // Reset while minutes conversion is in flight
    min_val = 6'd33;
    step(3'b010, "midrst_e0");
    step(3'b000, "midrst_e1");
    do_reset("midrst");
    min_val = 6'd48;
    step(3'b010, "post_e0");
    step(3'b000, "post_e1");
    step(3'b000, "post_e2");
    step(3'b000, "post_e3");

    // Random traffic including out-of-range values and value changes mid-flight
    for (int i = 0; i < 400; i++) begin
      sec_val = 6'($urandom); min_val = 6'($urandom); hr_val = 6'($urandom_range(0, 31));
      step(3'($urandom), "rand");
      if (i == 200) do_reset("rand_rst");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
